// File: rtl/decode_writeback.sv
// ---------------------------------------------------------------------------
// decode_writeback
// Decode-stage register read and writeback-stage register write for a
// Y86-64 style core: 15 x 64-bit registers (index 4 = %rsp, 4'hF = none).
//
// Ports
//   clk, rst_n      clock (writes on rising edge), async active-low reset
//   icode, ifun     instruction and function code (ifun only feeds the trace)
//   rA, rB          register specifiers, 4'hF = none
//   valE, valM      execute result and memory read data to write back
//   cnd             execute condition flag, qualifies cmovXX
//   wb_en           writeback strobe, commits dstE/dstM at the rising edge
//   valA, valB      combinational register reads for srcA/srcB
//   retired         count of committed writeback cycles (wraps)
//
// Configuration
//   REGFILE_BYPASS_EN  when defined, valA/valB forward the value being written
//                      in the current cycle (dstM has priority over dstE).
// ---------------------------------------------------------------------------
module decode_writeback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        cnd,
    input  logic        wb_en,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] retired
);

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREG   = 15;
    localparam int unsigned RIDX_W = 4;

    localparam logic [RIDX_W-1:0] RNONE = 4'hF;
    localparam logic [RIDX_W-1:0] RRSP  = 4'h4;

    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [XLEN-1:0]   rf [NREG];
    logic [RIDX_W-1:0] srcA, srcB, dstE, dstM;
    logic              we_e, we_m;

    // ifun is carried for the writeback trace only; no register selection uses it
    logic unused_ifun;
    assign unused_ifun = ^ifun;

    // Register selection from the instruction code
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        unique case (icode)
            I_CMOV: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            I_IRMOVQ: dstE = rB;
            I_RMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RRSP;
                dstE = RRSP;
            end
            I_RET: begin
                srcA = RRSP;
                srcB = RRSP;
                dstE = RRSP;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = RRSP;
                dstE = RRSP;
            end
            I_POPQ: begin
                srcA = RRSP;
                srcB = RRSP;
                dstE = RRSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    // popq %rsp: dstE == dstM, only the valM write survives
    assign we_e = wb_en && (dstE != RNONE) && (dstE != dstM);
    assign we_m = wb_en && (dstM != RNONE);

    // Port A read
    always_comb begin
        valA = '0;
        if (srcA != RNONE) begin
            valA = rf[srcA];
`ifdef REGFILE_BYPASS_EN
            if (rst_n && wb_en) begin
                if (srcA == dstM) begin
                    valA = valM;
                end else if (srcA == dstE) begin
                    valA = valE;
                end
            end
`endif
        end
    end

    // Port B read
    always_comb begin
        valB = '0;
        if (srcB != RNONE) begin
            valB = rf[srcB];
`ifdef REGFILE_BYPASS_EN
            if (rst_n && wb_en) begin
                if (srcB == dstM) begin
                    valB = valM;
                end else if (srcB == dstE) begin
                    valB = valE;
                end
            end
`endif
        end
    end

    // Register array and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf      <= '{default: '0};
            retired <= '0;
        end else begin
            if (we_e) begin
                rf[dstE] <= valE;
            end
            if (we_m) begin
                rf[dstM] <= valM;
            end
            if (wb_en) begin
                retired <= retired + XLEN'(1);
            end
        end
    end

endmodule

// File: doc/decode_writeback.md
DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all writes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: icode  input  4  instruction code of the instruction being decoded and written back.
REQ-004 SHALL have port: ifun  input  4  function code; used only for the writeback trace, not for register selection.
REQ-005 SHALL have port: rA  input  4  register specifier A; 4'hF = none.
REQ-006 SHALL have port: rB  input  4  register specifier B; 4'hF = none.
REQ-007 SHALL have port: valE  input  64  execute-stage result to write.
REQ-008 SHALL have port: valM  input  64  memory-stage read data to write.
REQ-009 SHALL have port: cnd  input  1  condition flag from execute; qualifies the cmovXX write.
REQ-010 SHALL have port: wb_en  input  1  writeback strobe; commits dstE/dstM writes at the rising edge.
REQ-011 SHALL have port: valA  output  64  register read for srcA.
REQ-012 SHALL have port: valB  output  64  register read for srcB.
REQ-013 SHALL have port: retired  output  64  count of committed writeback cycles.

Function
REQ-014 SHALL hold 15 registers of 64 bits, indexed 0..14; index 4 is %rsp; index 15 SHALL mean none.
REQ-015 SHALL select srcA: rA for icode 2,4,6,A; 4 for icode 9,B; else F.
REQ-016 SHALL select srcB: rB for icode 4,5,6; 4 for icode 8,9,A,B; else F.
REQ-017 SHALL select dstE: rB for icode 3 and 6; rB for icode 2 only when cnd=1, else F; 4 for icode 8,9,A,B; else F.
REQ-018 SHALL select dstM: rA for icode 5 and B; else F.
REQ-019 SHALL drive valA/valB combinationally from the register array; a source of F SHALL read 64'd0.
REQ-020 SHALL, at a rising edge with wb_en=1, write valE to dstE and valM to dstM; a destination of F SHALL write nothing.
REQ-021 SHALL, when dstE equals dstM (popq %rsp), write valM only.
REQ-022 SHALL perform no register write when wb_en=0, regardless of other inputs.
REQ-023 SHALL increment retired by 1 at every rising edge with wb_en=1; it SHALL wrap from 2^64-1 to 0.
REQ-024 SHALL treat unknown icode values (0,1,7,C-F) as no source and no destination; retired still increments.

Reset
REQ-025 SHALL, while rst_n=0, clear all 15 registers and retired to 0 immediately, independent of clk.
REQ-026 SHALL ignore wb_en while rst_n=0; a reset asserted in the same cycle as a write SHALL discard that write.
REQ-027 SHALL resume normal writes at the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with REGFILE_BYPASS_EN defined, return on valA/valB the value being written in the current cycle when wb_en=1 and the source matches dstM or dstE (dstM priority).
REQ-029 SHALL, without REGFILE_BYPASS_EN, return on valA/valB the stored pre-write value until after the rising edge.

Verification
REQ-030 SHALL check: reset, then icode=3 rB=2 valE=64'h1234, wb_en=1 for one edge -> reg 2 = 64'h1234, retired=1.
REQ-031 SHALL check: icode=2 rA=2 rB=5 cnd=0 valE=64'h1234, wb_en=1 -> reg 5 unchanged (0); repeat with cnd=1 -> reg 5 = 64'h1234.
REQ-032 SHALL check: icode=B rA=4 valE=64'h108 valM=64'hABCD, wb_en=1 -> %rsp = 64'hABCD.
REQ-033 SHALL check: icode=A rA=2 with %rsp=64'h100 -> valA=64'h1234, valB=64'h100; icode=0 -> valA=valB=0.
REQ-034 SHALL check: icode=6 rA=1 rB=1 valE=64'h7, wb_en=1, read same cycle -> valA=64'h7 with REGFILE_BYPASS_EN, old value without.
REQ-035 SHALL check: rst_n pulsed low mid-cycle with wb_en=1 -> all registers and retired read 0 before the next edge.
